// File: rtl/alu_shift_pipe_pkg.sv
// Shared types and helpers for the pipelined shift unit.
// The op code travels as a raw 3-bit field so that undefined encodings survive through the pipe.
package alu_shift_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_t;

  function automatic logic op_known(logic [2:0] op);
    return (op <= 3'd4);
  endfunction

  // Right shifts run on the bit-reversed operand so every level only shifts left.
  function automatic logic op_right(logic [2:0] op);
    return (op == SHIFT_SRL) || (op == SHIFT_SRA) || (op == SHIFT_ROR);
  endfunction

  function automatic logic op_rotate(logic [2:0] op);
    return (op == SHIFT_ROL) || (op == SHIFT_ROR);
  endfunction

endpackage

// File: rtl/alu_shift_pipe_if.sv
// Request/result bundle of the shift unit.
// The master side issues requests and consumes results; the slave side is the unit.
interface alu_shift_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) ();
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             op;
  logic [DATA_WIDTH-1:0]  rs1_data;
  logic [SHIFT_WIDTH-1:0] shamt;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  result;
  logic [TAG_WIDTH-1:0]   res_tag;
  logic                   busy;

  modport master (
    output flush, in_valid, op, rs1_data, shamt, tag, out_ready,
    input  in_ready, out_valid, result, res_tag, busy
  );

  modport slave (
    input  flush, in_valid, op, rs1_data, shamt, tag, out_ready,
    output in_ready, out_valid, result, res_tag, busy
  );
endinterface

// File: rtl/alu_shift_pipe_stage.sv
// One register slice of the log shifter: levels LEVEL_LO..LEVEL_HI in front of a valid/ready register.
// The last slice also undoes the entry bit reversal so the result leaves straight from a flop.
module alu_shift_stage
  import alu_shift_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int LEVEL_LO   = 0,
  parameter int LEVEL_HI   = 0,
  parameter bit LAST       = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               up_valid,
  output logic                               up_ready,
  input  logic [2:0]                         up_op,
  input  logic                               up_fill,
  input  logic [DATA_WIDTH-1:0]              up_data,
  input  logic [$clog2(DATA_WIDTH)-1:0]      up_shamt,
  input  logic [TAG_WIDTH-1:0]               up_tag,
  output logic                               dn_valid,
  input  logic                               dn_ready,
  output logic [2:0]                         dn_op,
  output logic                               dn_fill,
  output logic [DATA_WIDTH-1:0]              dn_data,
  output logic [$clog2(DATA_WIDTH)-1:0]      dn_shamt,
  output logic [TAG_WIDTH-1:0]               dn_tag
);
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

  logic                   valid_q;
  logic [2:0]             op_q;
  logic                   fill_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [SHIFT_WIDTH-1:0] shamt_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]  exit_data;

  // Level i shifts left by 2**i; vacated bits take the wrapped bits or the fill bit.
  always_comb begin
    shifted = up_data;
    for (int i = LEVEL_LO; i <= LEVEL_HI; i++) begin
      if (up_shamt[i]) begin
        if (op_rotate(up_op)) begin
          shifted = (shifted << (2**i)) | (shifted >> (DATA_WIDTH - 2**i));
        end else begin
          shifted = (shifted << (2**i)) |
                    (up_fill ? ~({DATA_WIDTH{1'b1}} << (2**i)) : {DATA_WIDTH{1'b0}});
        end
      end
    end
    exit_data = shifted;
    if (LAST && op_right(up_op)) begin
      for (int j = 0; j < DATA_WIDTH; j++) begin
        exit_data[j] = shifted[DATA_WIDTH-1-j];
      end
    end
  end

  assign up_ready = !valid_q || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      tag_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (up_ready) begin
        valid_q <= up_valid;
      end
      if (up_ready && up_valid && !flush) begin
        op_q    <= up_op;
        fill_q  <= up_fill;
        data_q  <= exit_data;
        shamt_q <= up_shamt;
        tag_q   <= up_tag;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_op    = op_q;
  assign dn_fill  = fill_q;
  assign dn_data  = data_q;
  assign dn_shamt = shamt_q;
  assign dn_tag   = tag_q;

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL/ROR unit with valid/ready backpressure, result tag and flush.
// Latency equals PIPE_STAGES; throughput is one op per cycle while the consumer is ready.
module alu_shift_pipe
  import alu_shift_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_shift_pipe_if.slave  bus
);
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

  logic [PIPE_STAGES:0]   valid_s;
  logic [PIPE_STAGES-1:0] up_rdy;
  logic [PIPE_STAGES-1:0] dn_rdy;
  logic [2:0]             op_s    [0:PIPE_STAGES];
  logic                   fill_s  [0:PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  data_s  [0:PIPE_STAGES];
  logic [SHIFT_WIDTH-1:0] shamt_s [0:PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   tag_s   [0:PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  entry_data;
  logic                   entry_fill;
  logic                   unused_tail;

  // Unknown ops enter as zero with zero fill, so every level yields 0 while the tag rides along.
  always_comb begin
    entry_data = '0;
    entry_fill = 1'b0;
    if (op_known(bus.op)) begin
      if (op_right(bus.op)) begin
        for (int j = 0; j < DATA_WIDTH; j++) begin
          entry_data[j] = bus.rs1_data[DATA_WIDTH-1-j];
        end
      end else begin
        entry_data = bus.rs1_data;
      end
      entry_fill = (bus.op == SHIFT_SRA) ? bus.rs1_data[DATA_WIDTH-1] : 1'b0;
    end
  end

  assign valid_s[0] = bus.in_valid && !bus.flush;
  assign op_s[0]    = bus.op;
  assign fill_s[0]  = entry_fill;
  assign data_s[0]  = entry_data;
  assign shamt_s[0] = bus.shamt;
  assign tag_s[0]   = bus.tag;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    localparam int LO = (k * SHIFT_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;
    localparam int HI = ((k + 1) * SHIFT_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES - 1;

    // Downstream readiness flattened from the stage valids to keep the ready chain acyclic.
    if (k == PIPE_STAGES - 1) begin : g_tail
      assign dn_rdy[k] = bus.out_ready;
    end else begin : g_mid
      assign dn_rdy[k] = bus.out_ready || !(&valid_s[PIPE_STAGES:k+2]);
    end

    alu_shift_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .LEVEL_LO   (LO),
      .LEVEL_HI   (HI),
      .LAST       (k == PIPE_STAGES - 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .up_valid (valid_s[k]),
      .up_ready (up_rdy[k]),
      .up_op    (op_s[k]),
      .up_fill  (fill_s[k]),
      .up_data  (data_s[k]),
      .up_shamt (shamt_s[k]),
      .up_tag   (tag_s[k]),
      .dn_valid (valid_s[k+1]),
      .dn_ready (dn_rdy[k]),
      .dn_op    (op_s[k+1]),
      .dn_fill  (fill_s[k+1]),
      .dn_data  (data_s[k+1]),
      .dn_shamt (shamt_s[k+1]),
      .dn_tag   (tag_s[k+1])
    );
  end

  assign bus.in_ready  = up_rdy[0] && !bus.flush;
  assign bus.out_valid = valid_s[PIPE_STAGES];
  assign bus.result    = data_s[PIPE_STAGES];
  assign bus.res_tag   = tag_s[PIPE_STAGES];
  assign bus.busy      = |valid_s[PIPE_STAGES:1];

  assign unused_tail = ^{op_s[PIPE_STAGES], fill_s[PIPE_STAGES], shamt_s[PIPE_STAGES], up_rdy};

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Directed bench for alu_shift_pipe (PIPE_STAGES=2) plus a random cross-check of 1/2/5-stage builds.
module tb_alu_shift_pipe;
  import alu_shift_pipe_pkg::*;

  localparam int W  = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_shift_pipe_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) b1 ();
  alu_shift_pipe_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) b2 ();
  alu_shift_pipe_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) b5 ();

  alu_shift_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(1), .TAG_WIDTH(TW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_shift_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(2), .TAG_WIDTH(TW)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  alu_shift_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(5), .TAG_WIDTH(TW)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] a, input int sh);
    case (op)
      3'd0:    return a << sh;
      3'd1:    return a >> sh;
      3'd2:    return 32'($signed(a) >>> sh);
      3'd3:    return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      3'd4:    return (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      default: return 32'h0;
    endcase
  endfunction

  // Present one op on b2 and check it appears exactly PIPE_STAGES edges later.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input int sh, input logic [4:0] tg, input logic [31:0] exp);
    @(posedge clk); #1;
    b2.in_valid = 1'b1; b2.op = op; b2.rs1_data = a; b2.shamt = 5'(sh); b2.tag = tg;
    #1 chk({name, " in_ready"}, b2.in_ready, 1'b1);
    @(posedge clk); #1;
    b2.in_valid = 1'b0; b2.rs1_data = 32'hDEAD_BEEF; b2.tag = 5'h1F;
    #1 chk({name, " early valid"}, b2.out_valid, 1'b0);
    @(posedge clk); #1;
    chk({name, " out_valid"}, b2.out_valid, 1'b1);
    chk({name, " result"}, b2.result, exp);
    chk({name, " tag"}, b2.res_tag, tg);
  endtask

  logic [36:0] q1[$], q2[$], q5[$];

  initial begin
    int sent, recv;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    logic        held_v;

    b1.flush = 0; b1.in_valid = 0; b1.op = 0; b1.rs1_data = 0; b1.shamt = 0; b1.tag = 0; b1.out_ready = 1;
    b2.flush = 0; b2.in_valid = 1; b2.op = 0; b2.rs1_data = 32'h55; b2.shamt = 1; b2.tag = 7; b2.out_ready = 1;
    b5.flush = 0; b5.in_valid = 0; b5.op = 0; b5.rs1_data = 0; b5.shamt = 0; b5.tag = 0; b5.out_ready = 1;

    // Reset with a request pending
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", b2.out_valid, 1'b0);
    chk("reset result", b2.result, 32'h0);
    chk("reset tag", b2.res_tag, 5'h0);
    chk("reset busy", b2.busy, 1'b0);
    rst_n = 1'b1;
    b2.in_valid = 1'b0;
    #1 chk("post-reset in_ready", b2.in_ready, 1'b1);

    // Single ops with hand-computed results
    issue("sll",        SHIFT_SLL, 32'h0000_00F1, 4,  5'd3,  32'h0000_0F10);
    issue("sra",        SHIFT_SRA, 32'h8000_0010, 4,  5'd4,  32'hF800_0001);
    issue("srl",        SHIFT_SRL, 32'h8000_0010, 4,  5'd5,  32'h0800_0001);
    issue("sra sh0",    SHIFT_SRA, 32'h8000_0010, 0,  5'd6,  32'h8000_0010);
    issue("ror sh0",    SHIFT_ROR, 32'h0000_00A5, 0,  5'd7,  32'h0000_00A5);
    issue("ror 1",      SHIFT_ROR, 32'h0000_0001, 1,  5'd8,  32'h8000_0000);
    issue("rol 31",     SHIFT_ROL, 32'h8000_0001, 31, 5'd9,  32'hC000_0000);
    issue("sra 31 neg", SHIFT_SRA, 32'h8000_0000, 31, 5'd10, 32'hFFFF_FFFF);
    issue("sra 31 pos", SHIFT_SRA, 32'h7000_0000, 31, 5'd11, 32'h0000_0000);
    issue("srl 31",     SHIFT_SRL, 32'hFFFF_FFFF, 31, 5'd12, 32'h0000_0001);
    issue("sll 31",     SHIFT_SLL, 32'h0000_0001, 31, 5'd13, 32'h8000_0000);
    issue("undef op",   3'd7,      32'h0000_1234, 3,  5'd31, 32'h0000_0000);

    // Eight ops back to back with a five-cycle consumer stall
    sent = 0; recv = 0; held_v = 1'b0; held_res = '0; held_tag = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      b2.out_ready = !(cyc >= 2 && cyc < 7);
      b2.in_valid  = (sent < 8);
      b2.op        = SHIFT_SLL;
      b2.rs1_data  = 32'(sent + 1);
      b2.shamt     = 5'(sent);
      b2.tag       = 5'(sent + 8);
      #1;
      chk("stall in_ready", b2.in_ready, (b2.out_ready || (sent - recv) < 2));
      if (!b2.out_ready && b2.out_valid) begin
        if (held_v) begin
          chk("stall result stable", b2.result, held_res);
          chk("stall tag stable", b2.res_tag, held_tag);
        end
        held_res = b2.result; held_tag = b2.res_tag; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (b2.out_valid && b2.out_ready) begin
        chk("stall no extra output", (recv < 8), 1'b1);
        chk("stall result order", b2.result, 32'(recv + 1) << recv);
        chk("stall tag order", b2.res_tag, 5'(recv + 8));
        recv++;
      end
      if (b2.in_valid && b2.in_ready) sent++;
    end
    chk("stall all received", recv, 8);
    chk("stall drained valid", b2.out_valid, 1'b0);
    chk("stall drained busy", b2.busy, 1'b0);

    // Flush a full pipe while a new request is offered
    @(posedge clk); #1;
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.op = SHIFT_SLL; b2.rs1_data = 32'h1; b2.shamt = 5'd1; b2.tag = 5'd1;
    @(posedge clk); #1;
    b2.rs1_data = 32'h2; b2.tag = 5'd2;
    @(posedge clk); #1;
    b2.rs1_data = 32'h3; b2.tag = 5'd9; b2.flush = 1'b1; b2.out_ready = 1'b1;
    #1;
    chk("flush in_ready", b2.in_ready, 1'b0);
    chk("flush full valid", b2.out_valid, 1'b1);
    chk("flush full busy", b2.busy, 1'b1);
    @(posedge clk); #1;
    b2.flush = 1'b0; b2.in_valid = 1'b0;
    #1;
    chk("flush out_valid", b2.out_valid, 1'b0);
    chk("flush busy", b2.busy, 1'b0);
    @(posedge clk); #1;
    chk("flush no accept valid", b2.out_valid, 1'b0);
    chk("flush no accept busy", b2.busy, 1'b0);

    // Random ops on the 1/2/5-stage builds against the reference model
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic        v;
      logic [2:0]  op;
      logic [31:0] a;
      int          sh;
      logic [4:0]  tg;
      logic [36:0] exp;
      @(posedge clk); #1;
      v  = (cyc < 250) && ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      sh = $urandom_range(0, 31);
      tg = 5'($urandom_range(0, 31));
      b1.in_valid = v; b1.op = op; b1.rs1_data = a; b1.shamt = 5'(sh); b1.tag = tg;
      b2.in_valid = v; b2.op = op; b2.rs1_data = a; b2.shamt = 5'(sh); b2.tag = tg;
      b5.in_valid = v; b5.op = op; b5.rs1_data = a; b5.shamt = 5'(sh); b5.tag = tg;
      #1;
      exp = {tg, ref_shift(op, a, sh)};
      if (b1.out_valid) begin
        chk("rand p1 expected output", (q1.size() > 0), 1'b1);
        if (q1.size() > 0) chk("rand p1 result", {b1.res_tag, b1.result}, q1.pop_front());
      end
      if (b2.out_valid) begin
        chk("rand p2 expected output", (q2.size() > 0), 1'b1);
        if (q2.size() > 0) chk("rand p2 result", {b2.res_tag, b2.result}, q2.pop_front());
      end
      if (b5.out_valid) begin
        chk("rand p5 expected output", (q5.size() > 0), 1'b1);
        if (q5.size() > 0) chk("rand p5 result", {b5.res_tag, b5.result}, q5.pop_front());
      end
      if (v && b1.in_ready) q1.push_back(exp);
      if (v && b2.in_ready) q2.push_back(exp);
      if (v && b5.in_ready) q5.push_back(exp);
    end
    chk("rand p1 drained", q1.size(), 0);
    chk("rand p2 drained", q2.size(), 0);
    chk("rand p5 drained", q5.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
